queue_obj: RTL and testbench
============================

Name: queue_obj

Overview:
- Circular FIFO used as the physical-register free list in the rename stage.
- Returns freed physical register tags (enque) and hands out new tags (deque); the head tag is always visible combinationally.
- On pipeline flush it rebuilds its contents from the retirement register map.
- Asserts halt when no tags remain, which stalls rename.

Parameters:
- INIT, 1: 1 = reset preloads the queue with tags LENGTH..2*LENGTH-1; 0 = reset leaves the queue empty.
- LENGTH, 32: queue capacity in entries; also the number of entries in r_mapping (architectural registers).
- WIDTH, 6: bits per entry (tag width). Tag space is 0..2^WIDTH-1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- stall, input, 1: freezes the queue (no enque, no deque).
- flush, input, 1: rebuild contents from r_mapping.
- enque, input, 1: push enque_data at the tail.
- enque_data, input, WIDTH: tag being freed.
- deque, input, 1: pop the head entry.
- deque_data, output, WIDTH: combinational head entry, i.e. mem[head].
- r_mapping, input, LENGTH x WIDTH (unpacked array [LENGTH-1:0]): committed arch->phys map.
- halt, output, 1: combinational; 1 when the queue is empty (count==0).

Behaviour:
- State: mem[LENGTH], head, tail (log2(LENGTH) bits each, wrap modulo LENGTH), count (0..LENGTH).
- Update priority at posedge clk: reset > flush > stall > normal operation.

Reset:
- head=0.
- INIT=1: mem[i]=LENGTH+i, tail=0 (wrapped), count=LENGTH. Default parameters give tags 32..63 with head tag 32.
- INIT=0: tail=0, count=0, mem contents don't-care.

Flush:
- Scan tags t=0..2^WIDTH-1 in ascending order. Each t not equal to any r_mapping[j] is written to consecutive entries starting at mem[0], up to LENGTH entries.
- head=0, tail=number written mod LENGTH, count=number written.
- enque and deque in the flush cycle are ignored.
- Flush is a single-cycle operation; the new head is visible on the next cycle.

Stall: pointers, count and mem are held.

Normal operation:
- The pop is effective only when deque=1 and count>0: head<=head+1.
- The push is effective only when enque=1 and count<LENGTH: mem[tail]<=enque_data, tail<=tail+1.
- count <= count + push - pop.
- Simultaneous push and pop with 0<count<LENGTH: both occur and count is unchanged.
- Push while empty with deque=1: only the push occurs. The pushed tag becomes the head next cycle and halt deasserts next cycle.
- Pop while empty: ignored and count stays 0. The consumer must honour halt.
- Push while full: ignored (the data is dropped).

Outputs:
- deque_data=mem[head] at all times. When empty the value is stale and meaningless.
- halt=(count==0). Reset value is 0 for INIT=1 and 1 for INIT=0.
- No output latency beyond the register update: a pop at edge k exposes the next head after edge k.

Test Plan:
- Reset, INIT=1 -> count=32, deque_data=32, halt=0.
- deque held for 32 cycles -> deque_data sequence 32,33,...,63; halt=1 after the 32nd edge; further deque leaves count at 0.
- From empty, enque=1 with enque_data=5 (deque also 1) -> after the edge halt=0, deque_data=5, count=1. Then enque 7 plus deque in the same cycle -> deque_data=7, count=1.
- r_mapping identity except r_mapping[3]=40, then flush -> free list 3,32..39,41..63 (32 entries); deque_data=3, halt=0; successive pops yield 32, then 33.
- stall=1 with enque and deque both 1 -> deque_data and count unchanged. Also: reset asserted mid-operation, same cycle as flush -> INIT preload wins.
- Tail wrap: pop 4 entries, then enque 10,11,12,13 -> count=32, and after 28 further pops deque_data sequence reaches 10,11,12,13. A fifth enque while full is dropped.

Source files
------------

// File: rtl/queue_obj.sv
// Circular free list of physical register tags for the rename stage.
// Tags are returned at the tail and handed out from the head. A flush rebuilds the list from the committed map.
module queue_obj #(
    parameter int INIT   = 1,
    parameter int LENGTH = 32,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             enque,
    input  logic [WIDTH-1:0] enque_data,
    input  logic             deque,
    output logic [WIDTH-1:0] deque_data,
    input  logic [WIDTH-1:0] r_mapping [LENGTH-1:0],
    output logic             halt
);

    localparam int PTR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CNT_W = $clog2(LENGTH + 1);
    localparam int NTAGS = 1 << WIDTH;

    logic [WIDTH-1:0] mem [LENGTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;

    logic [NTAGS-1:0] tag_used;
    logic [WIDTH-1:0] flush_mem [LENGTH];
    logic [CNT_W-1:0] flush_cnt;
    logic [PTR_W-1:0] flush_tail;

    // LENGTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(LENGTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign push = enque && (count < CNT_W'(LENGTH));
    assign pop  = deque && (count != '0);

    assign deque_data = mem[head];
    assign halt       = (count == '0);

    // Flush image: every tag absent from the committed map, in ascending order.
    always_comb begin
        tag_used  = '0;
        flush_cnt = '0;
        for (int j = 0; j < LENGTH; j++) begin
            tag_used[r_mapping[j]] = 1'b1;
        end
        for (int i = 0; i < LENGTH; i++) begin
            flush_mem[i] = '0;
        end
        for (int t = 0; t < NTAGS; t++) begin
            if (!tag_used[t] && (flush_cnt < CNT_W'(LENGTH))) begin
                flush_mem[flush_cnt[PTR_W-1:0]] = WIDTH'(t);
                flush_cnt = flush_cnt + CNT_W'(1);
            end
        end
    end

    assign flush_tail = (flush_cnt == CNT_W'(LENGTH)) ? '0 : flush_cnt[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            if (INIT != 0) begin
                count <= CNT_W'(LENGTH);
                for (int i = 0; i < LENGTH; i++) begin
                    mem[i] <= WIDTH'(LENGTH + i);
                end
            end else begin
                count <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= flush_tail;
            count <= flush_cnt;
            for (int i = 0; i < LENGTH; i++) begin
                mem[i] <= flush_mem[i];
            end
        end else if (!stall) begin
            if (push) begin
                mem[tail] <= enque_data;
                tail      <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            // A push into an empty queue with deque held performs only the push.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_obj.sv
// Directed testbench for the queue_obj free list (default parameters: 32 entries, 6-bit tags).
module tb_queue_obj;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       flush;
    logic       enque;
    logic [5:0] enque_data;
    logic       deque;
    logic [5:0] deque_data;
    logic [5:0] r_mapping [31:0];
    logic       halt;

    int n_cmp;
    int n_err;

    queue_obj #(.INIT(1), .LENGTH(32), .WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .enque      (enque),
        .enque_data (enque_data),
        .deque      (deque),
        .deque_data (deque_data),
        .r_mapping  (r_mapping),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (halt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_halt: got %0d want 0", halt);
        end
        n_cmp++;
        if (deque_data !== 6'd32) begin
            n_err++;
            $display("FAIL reset_head: got %0d want 32", deque_data);
        end
    endtask

    task automatic test_drain();
        do_reset();
        deque = 1'b1;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (deque_data !== 6'(32 + i) || halt !== 1'b0) begin
                n_err++;
                $display("FAIL drain_data[%0d]: got %0d halt %0d want %0d halt 0", i, deque_data, halt, 32 + i);
            end
            step();
        end
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL drain_empty_halt: got %0d want 1", halt);
        end
        step();
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL pop_while_empty_halt: got %0d want 1", halt);
        end
        enque      = 1'b1;
        enque_data = 6'd5;
        step();
        n_cmp++;
        if (halt !== 1'b0 || deque_data !== 6'd5) begin
            n_err++;
            $display("FAIL push_empty: got data %0d halt %0d want data 5 halt 0", deque_data, halt);
        end
        enque_data = 6'd7;
        step();
        n_cmp++;
        if (halt !== 1'b0 || deque_data !== 6'd7) begin
            n_err++;
            $display("FAIL push_pop_one: got data %0d halt %0d want data 7 halt 0", deque_data, halt);
        end
        enque = 1'b0;
        step();
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL count_one_pop_halt: got %0d want 1", halt);
        end
        deque = 1'b0;
    endtask

    task automatic test_flush();
        logic [5:0] exp;
        do_reset();
        for (int j = 0; j < 32; j++) r_mapping[j] = 6'(j);
        r_mapping[3] = 6'd40;
        flush      = 1'b1;
        enque      = 1'b1;
        deque      = 1'b1;
        enque_data = 6'd9;
        step();
        flush = 1'b0;
        enque = 1'b0;
        n_cmp++;
        if (deque_data !== 6'd3 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL flush_head: got data %0d halt %0d want data 3 halt 0", deque_data, halt);
        end
        // Expected free list: 3, 32..39, 41..63.
        for (int k = 0; k < 32; k++) begin
            exp = (k == 0) ? 6'd3 : (k <= 8) ? 6'(31 + k) : 6'(32 + k);
            n_cmp++;
            if (deque_data !== exp || halt !== 1'b0) begin
                n_err++;
                $display("FAIL flush_seq[%0d]: got %0d halt %0d want %0d halt 0", k, deque_data, halt, exp);
            end
            step();
        end
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL flush_count_halt: got %0d want 1", halt);
        end
        deque = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        deque = 1'b1;
        step();
        stall      = 1'b1;
        enque      = 1'b1;
        enque_data = 6'd9;
        step();
        step();
        n_cmp++;
        if (deque_data !== 6'd33 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold: got data %0d halt %0d want data 33 halt 0", deque_data, halt);
        end
        stall = 1'b0;
        enque = 1'b0;
        for (int i = 0; i < 31; i++) begin
            n_cmp++;
            if (deque_data !== 6'(33 + i)) begin
                n_err++;
                $display("FAIL stall_drain[%0d]: got %0d want %0d", i, deque_data, 33 + i);
            end
            step();
        end
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL stall_count_halt: got %0d want 1", halt);
        end
        deque = 1'b0;
    endtask

    task automatic test_reset_over_flush();
        do_reset();
        deque = 1'b1;
        step();
        step();
        step();
        for (int j = 0; j < 32; j++) r_mapping[j] = 6'(j + 32);
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        deque = 1'b0;
        n_cmp++;
        if (deque_data !== 6'd32 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wins_flush: got data %0d halt %0d want data 32 halt 0", deque_data, halt);
        end
        deque = 1'b1;
        step();
        deque = 1'b0;
        n_cmp++;
        if (deque_data !== 6'd33) begin
            n_err++;
            $display("FAIL reset_wins_pop: got %0d want 33", deque_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Full: the push is dropped, only the pop happens.
        enque      = 1'b1;
        deque      = 1'b1;
        enque_data = 6'd2;
        step();
        n_cmp++;
        if (deque_data !== 6'd33) begin
            n_err++;
            $display("FAIL b2b_full: got %0d want 33", deque_data);
        end
        enque_data = 6'd4;
        step();
        n_cmp++;
        if (deque_data !== 6'd34) begin
            n_err++;
            $display("FAIL b2b_mid: got %0d want 34", deque_data);
        end
        enque = 1'b0;
        for (int i = 0; i < 30; i++) begin
            n_cmp++;
            if (deque_data !== 6'(34 + i)) begin
                n_err++;
                $display("FAIL b2b_drain[%0d]: got %0d want %0d", i, deque_data, 34 + i);
            end
            step();
        end
        n_cmp++;
        if (deque_data !== 6'd4 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_tail: got data %0d halt %0d want data 4 halt 0", deque_data, halt);
        end
        step();
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_halt: got %0d want 1", halt);
        end
        deque = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        deque = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (deque_data !== 6'(32 + i)) begin
                n_err++;
                $display("FAIL wrap_pop[%0d]: got %0d want %0d", i, deque_data, 32 + i);
            end
            step();
        end
        deque = 1'b0;
        enque = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enque_data = 6'(10 + i);
            step();
        end
        enque = 1'b0;
        deque = 1'b1;
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (deque_data !== ((k < 28) ? 6'(36 + k) : 6'(k - 18)) || halt !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_seq[%0d]: got %0d halt %0d want %0d halt 0", k, deque_data, halt,
                         (k < 28) ? 36 + k : k - 18);
            end
            step();
        end
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_full_drop: got halt %0d want 1", halt);
        end
        deque = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        enque      = 1'b0;
        enque_data = '0;
        deque      = 1'b0;
        for (int j = 0; j < 32; j++) r_mapping[j] = 6'(j);
        step();
        test_reset();
        test_drain();
        test_flush();
        test_stall();
        test_reset_over_flush();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
